// File: rtl/vga_pkg.sv
// vga_pkg: SVGA 800x600@60 Hz timing constants and shared types for the
// raster timing generator and the renderers that consume row/col.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1056
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 628

    typedef logic [9:0]  coord_t;   // active-region coordinate
    typedef logic [10:0] cnt_t;     // raw raster counter

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: enabled up-counter with modulus MODULUS.
// Ports:
//   clock, reset  - clock, asynchronous active-low reset (count -> 0)
//   en            - advance by one on a rising edge
//   clear         - synchronous clear to 0, wins over en
//   wrap          - at the last value, return to 0 when set, hold otherwise
//   count         - current value, 0..MODULUS-1
//   at_max        - count == MODULUS-1
module wrap_counter
    import vga_pkg::*;
#(
    parameter int WIDTH   = $bits(cnt_t),
    parameter int MODULUS = H_TOTAL
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    assign at_max = (count == MAX_VAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (at_max) begin
                if (wrap) count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: SVGA raster timing source. Produces hsync/vsync, blank and
// the clamped row/col stream for the renderers, plus frame/line markers.
// Ports:
//   clock        - 40 MHz pixel clock
//   reset        - asynchronous active-low reset
//   pix_en       - advance enable; nothing moves while low
//   row, col     - active-region line / pixel, forced to 0 outside it
//   hsync, vsync - active-high sync pulses
//   blank        - high outside the active region
//   frame_start  - one-cycle marker at pixel (0,0), qualified by pix_en
//   line_end     - one-cycle marker at the last pixel of each line
// Build option: define VGA_OUT_PIPE_EN to register every output behind one
// pix_en-qualified flop stage (one enabled cycle of latency).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
)(
    input  logic   clock,
    input  logic   reset,
    input  logic   pix_en,
    output coord_t row,
    output coord_t col,
    output logic   hsync,
    output logic   vsync,
    output logic   blank,
    output logic   frame_start,
    output logic   line_end
);

    localparam int   H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t   h_cnt, v_cnt;
    logic   h_at_max;
    logic   v_wrap_unused;

    coord_t row_c, col_c;
    logic   hsync_c, vsync_c, blank_c, fs_c, le_c;

    wrap_counter #(.WIDTH($bits(cnt_t)), .MODULUS(H_TOT)) u_h_cnt (
        .clock  (clock),
        .reset  (reset),
        .en     (pix_en),
        .clear  (1'b0),
        .wrap   (1'b1),
        .count  (h_cnt),
        .at_max (h_at_max)
    );

    // Vertical counter steps once per line, on the last enabled pixel.
    wrap_counter #(.WIDTH($bits(cnt_t)), .MODULUS(V_TOT)) u_v_cnt (
        .clock  (clock),
        .reset  (reset),
        .en     (pix_en & h_at_max),
        .clear  (1'b0),
        .wrap   (1'b1),
        .count  (v_cnt),
        .at_max (v_wrap_unused)
    );

    always_comb begin
        hsync_c = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vsync_c = (v_cnt >= VS_START) && (v_cnt < VS_END);
        blank_c = (h_cnt >= H_ACT_C) || (v_cnt >= V_ACT_C);
        // Clamp to 0 outside the active area so sinks need no range checks.
        col_c   = (h_cnt < H_ACT_C) ? h_cnt[9:0] : '0;
        row_c   = (v_cnt < V_ACT_C) ? v_cnt[9:0] : '0;
        // Markers are gated by pix_en so a stall cannot repeat them.
        fs_c    = pix_en && (h_cnt == '0) && (v_cnt == '0);
        le_c    = pix_en && h_at_max;
    end

`ifdef VGA_OUT_PIPE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row         <= '0;
            col         <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else if (pix_en) begin
            row         <= row_c;
            col         <= col_c;
            hsync       <= hsync_c;
            vsync       <= vsync_c;
            blank       <= blank_c;
            frame_start <= fs_c;
            line_end    <= le_c;
        end
    end
`else
    assign row         = row_c;
    assign col         = col_c;
    assign hsync       = hsync_c;
    assign vsync       = vsync_c;
    assign blank       = blank_c;
    assign frame_start = fs_c;
    assign line_end    = le_c;
`endif

endmodule
